// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA timing block
// and the object renderers that place themselves on the 640x480 raster.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
  localparam int VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus from the timing generator to the renderers and the colour mux.
interface vga_timing_if;
  import vga_pkg::*;

  coord_t col;
  coord_t row;
  logic   pix_en;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_tick;

  modport master (output col, row, pix_en, hsync, vsync, video_on, frame_tick);
  modport slave  (input  col, row, pix_en, hsync, vsync, video_on, frame_tick);
endinterface

// File: rtl/vga_timing_clk_en_div.sv
// Clock-enable divider: adv_o flags the clk cycle that ends each CLK_DIV period,
// pix_en_o is the registered pulse for that same cycle (held low through reset).
module clk_en_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic adv_o,
  output logic pix_en_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             pix_en_q;
  logic             pix_en_d;
  logic             wrap_s;

  always_comb begin
    wrap_s = (div_cnt_q == DIV_LAST);
    if (wrap_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    pix_en_d = (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign adv_o    = wrap_s;
  assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: column/row counters advanced by the pixel divider, with
// sync, blanking and frame strobe registered from the next counter values.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV         = 1,
  parameter int H_VISIBLE       = H_VISIBLE_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_VISIBLE       = V_VISIBLE_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam coord_t H_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS     = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS     = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO     = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO     = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic   SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic   adv_s;
  logic   pix_en_s;
  logic   hs_act_s;
  logic   vs_act_s;
  coord_t col_q, col_d;
  coord_t row_q, row_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_tick_q, frame_tick_d;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv_o    (adv_s),
    .pix_en_o (pix_en_s)
  );

  // Counters wrap by compare; decoded outputs only move on a pixel advance so
  // video_on stays low until the first advance after reset.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    frame_tick_d = 1'b0;
    hs_act_s     = 1'b0;
    vs_act_s     = 1'b0;
    if (adv_s) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + coord_t'(1);
        end
      end else begin
        col_d = col_q + coord_t'(1);
      end
      hs_act_s     = in_range(col_d, HS_LO, HS_HI);
      vs_act_s     = in_range(row_d, VS_LO, VS_HI);
      hsync_d      = hs_act_s ? ~SYNC_IDLE : SYNC_IDLE;
      vsync_d      = vs_act_s ? ~SYNC_IDLE : SYNC_IDLE;
      video_on_d   = (col_d < H_VIS) && (row_d < V_VIS);
      frame_tick_d = (col_d == coord_t'(0)) && (row_d == V_VIS);
    end else begin
      frame_tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.col        = col_q;
  assign vga.row        = row_q;
  assign vga.pix_en     = pix_en_s;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.frame_tick = frame_tick_q;

endmodule
